// File: rtl/data_memory_dump.sv
// Byte-addressable big-endian data memory with combinational loads, clocked stores
// and a start-triggered FSM that streams an address window one byte per accepted beat.
module data_memory_dump #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_BYTES = 1024
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic [1:0]  MEM_read_length,
  input  logic        MEM_read_signed,
  input  logic [31:0] MEM_read_address,
  output logic [31:0] MEM_read_data,
  output logic        MEM_read_fault,
  input  logic [1:0]  MEM_write_length,
  input  logic [31:0] MEM_write_address,
  input  logic [31:0] MEM_write_data,
  output logic        MEM_write_fault,
  input  logic        dump_start,
  input  logic [31:0] dump_first,
  input  logic [31:0] dump_last,
  input  logic        transmitter_buffer_full,
  output logic        DMEM_transmit_request,
  output logic [7:0]  DMEM_data_transmit,
  output logic        dump_busy,
  output logic        dump_done,
  output logic        dump_error,
  output logic [1:0]  dump_state
);
  localparam int          AW    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [31:0] DEPTH = 32'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;

  logic [7:0] mem [DEPTH_BYTES];

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b01:   return 3'd1;
      2'b10:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Offset is unsigned, so addresses below the base wrap high and fail the bound.
  function automatic logic in_range(input logic [31:0] addr, input logic [2:0] n);
    return (addr - BASE_ADDR) <= (DEPTH - 32'(n));
  endfunction

  function automatic logic aligned(input logic [1:0] low, input logic [2:0] n);
    case (n)
      3'd4:    return low == 2'b00;
      3'd2:    return low[0] == 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  logic [2:0]    rd_n;
  logic [AW-1:0] rd_idx;
  logic [7:0]    rb0, rb1, rb2, rb3;

  always_comb begin
    rd_n           = len_bytes(MEM_read_length);
    rd_idx         = AW'(MEM_read_address - BASE_ADDR);
    MEM_read_fault = !aligned(MEM_read_address[1:0], rd_n) || !in_range(MEM_read_address, rd_n);
    rb0            = mem[rd_idx];
    rb1            = mem[rd_idx + AW'(1)];
    rb2            = mem[rd_idx + AW'(2)];
    rb3            = mem[rd_idx + AW'(3)];
    MEM_read_data  = 32'h0;
    if (!MEM_read_fault) begin
      case (rd_n)
        3'd1:    MEM_read_data = {{24{MEM_read_signed & rb0[7]}}, rb0};
        3'd2:    MEM_read_data = {{16{MEM_read_signed & rb0[7]}}, rb0, rb1};
        default: MEM_read_data = {rb0, rb1, rb2, rb3};
      endcase
    end
  end

  logic [2:0]    wr_n;
  logic [AW-1:0] wr_idx;

  always_comb begin
    wr_n            = len_bytes(MEM_write_length);
    wr_idx          = AW'(MEM_write_address - BASE_ADDR);
    MEM_write_fault = (MEM_write_length != 2'b00) &&
                      (!aligned(MEM_write_address[1:0], wr_n) || !in_range(MEM_write_address, wr_n));
  end

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
    end else if (MEM_write_length != 2'b00 && !MEM_write_fault) begin
      case (MEM_write_length)
        2'b01: mem[wr_idx] <= MEM_write_data[7:0];
        2'b10: begin
          mem[wr_idx]          <= MEM_write_data[15:8];
          mem[wr_idx + AW'(1)] <= MEM_write_data[7:0];
        end
        default: begin
          mem[wr_idx]          <= MEM_write_data[31:24];
          mem[wr_idx + AW'(1)] <= MEM_write_data[23:16];
          mem[wr_idx + AW'(2)] <= MEM_write_data[15:8];
          mem[wr_idx + AW'(3)] <= MEM_write_data[7:0];
        end
      endcase
    end
  end

  // Dump channel handshake: a beat transfers when DMEM_transmit_request is high and
  // transmitter_buffer_full is low in the same cycle; otherwise ptr and data hold.
  state_t      state;
  logic [31:0] ptr;
  logic [31:0] end_addr;
  logic        win_ok;

  assign win_ok = in_range(dump_first, 3'd1) && in_range(dump_last, 3'd1) && (dump_first <= dump_last);

  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state      <= IDLE;
      ptr        <= BASE_ADDR;
      end_addr   <= BASE_ADDR;
      dump_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (dump_start) begin
          dump_error <= !win_ok;
          if (win_ok) begin
            ptr      <= dump_first;
            end_addr <= dump_last;
            state    <= SEND;
          end else begin
            state <= DONE;
          end
        end
        SEND: if (!transmitter_buffer_full) begin
          if (ptr == end_addr) state <= DONE;
          else                 ptr   <= ptr + 32'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The dump byte is read live so a store to ptr shows on the very next cycle.
  assign DMEM_data_transmit    = mem[AW'(ptr - BASE_ADDR)];
  assign DMEM_transmit_request = (state == SEND);
  assign dump_busy             = (state == SEND);
  assign dump_done             = (state == DONE);
  assign dump_state            = state;
endmodule

// File: tb/tb_data_memory_dump.sv
// Bench for data_memory_dump: byte-array reference model, queued expectations for
// loads, store faults and dump beats, checked by a negedge monitor.
module tb_data_memory_dump;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd_len;
  logic        rd_sgn;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_fault;
  logic [1:0]  wr_len;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_fault;
  logic        start;
  logic [31:0] first_a;
  logic [31:0] last_a;
  logic        full;
  logic        req;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  state_dbg;

  data_memory_dump #(.BASE_ADDR(BASE), .DEPTH_BYTES(DEPTH)) dut (
    .SYS_clk(clk), .SYS_reset(reset),
    .MEM_read_length(rd_len), .MEM_read_signed(rd_sgn), .MEM_read_address(rd_addr),
    .MEM_read_data(rd_data), .MEM_read_fault(rd_fault),
    .MEM_write_length(wr_len), .MEM_write_address(wr_addr), .MEM_write_data(wr_data),
    .MEM_write_fault(wr_fault),
    .dump_start(start), .dump_first(first_a), .dump_last(last_a),
    .transmitter_buffer_full(full),
    .DMEM_transmit_request(req), .DMEM_data_transmit(tx_data),
    .dump_busy(busy), .dump_done(done), .dump_error(err), .dump_state(state_dbg)
  );

  always #5 clk = ~clk;

  logic [7:0]  model [DEPTH];
  logic [32:0] ld_q [$];
  logic        wf_q [$];
  logic [7:0]  exp_q [$];
  logic [32:0] ld_e;
  logic        wf_e;
  logic [7:0]  bt_e;
  bit          ld_pend = 0;
  bit          wf_pend = 0;
  int          n_cmp = 0, n_bad = 0, beat_cnt = 0, done_cnt = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b01) ? 1 : (len == 2'b10) ? 2 : 4;
  endfunction

  function automatic bit acc_fault(input logic [31:0] addr, input int n);
    longint off = longint'(addr) - longint'(BASE);
    return (off < 0) || (off + n > DEPTH) || ((addr % n) != 0);
  endfunction

  function automatic logic [32:0] exp_load(input logic [31:0] addr, input logic [1:0] len, input bit sgn);
    int     n = nbytes(len);
    longint v = 0;
    int     off;
    if (acc_fault(addr, n)) return {1'b1, 32'h0};
    off = int'(addr - BASE);
    for (int i = 0; i < n; i++) v = v * 256 + longint'(model[off + i]);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return {1'b0, v[31:0]};
  endfunction

  // Monitor: every pending expectation is popped and compared here.
  always @(negedge clk) begin
    if (ld_pend) begin
      if (ld_q.size() == 0) check("load_queue_empty", 1, 0);
      else begin ld_e = ld_q.pop_front(); check("load", {rd_fault, rd_data}, ld_e); end
    end
    if (wf_pend) begin
      if (wf_q.size() == 0) check("wfault_queue_empty", 1, 0);
      else begin wf_e = wf_q.pop_front(); check("write_fault", wr_fault, wf_e); end
    end
    if (!reset) begin
      if (req && !full) begin
        beat_cnt++;
        if (exp_q.size() == 0) check("dump_unexpected_beat", tx_data, 0);
        else begin bt_e = exp_q.pop_front(); check("dump_beat", tx_data, bt_e); end
      end
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", busy, 0);
      end
    end
  end

  task automatic do_store(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
    int n = nbytes(len);
    bit f = (len != 2'b00) && acc_fault(addr, n);
    wr_addr = addr; wr_len = len; wr_data = data;
    wf_q.push_back(f); wf_pend = 1;
    if (len != 2'b00 && !f) begin
      int off = int'(addr - BASE);
      for (int i = 0; i < n; i++) model[off + i] = 8'(data >> (8 * (n - 1 - i)));
    end
    @(posedge clk); #1;
    wr_len = 2'b00; wf_pend = 0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [1:0] len, input bit sgn);
    rd_addr = addr; rd_len = len; rd_sgn = sgn;
    ld_q.push_back(exp_load(addr, len, sgn)); ld_pend = 1;
    @(posedge clk); #1;
    ld_pend = 0;
  endtask

  // mode 0: never full, 1: full pattern 0,1,1,0, 2: random full.
  task automatic run_dump(input logic [31:0] f, input logic [31:0] l, input int mode,
                          input bit exp_err, input int exp_beats, input int exp_cyc);
    int d0 = done_cnt, b0 = beat_cnt, cyc = 0, k = 0;
    if (!exp_err) for (longint a = longint'(f); a <= longint'(l); a++) exp_q.push_back(model[int'(a - longint'(BASE))]);
    first_a = f; last_a = l; start = 1;
    @(posedge clk); #1;
    start = 0;
    while (done_cnt == d0 && cyc < 300) begin
      case (mode)
        1:       full = (k % 4 == 1) || (k % 4 == 2);
        2:       full = 1'($urandom_range(0, 1));
        default: full = 1'b0;
      endcase
      k++;
      @(posedge clk); #1;
      cyc++;
    end
    full = 1'b0;
    check("dump_done_seen", done_cnt - d0, 1);
    check("dump_beats", beat_cnt - b0, exp_beats);
    check("dump_leftover", exp_q.size(), 0);
    check("dump_error", err, exp_err);
    if (exp_cyc >= 0) check("dump_cycles", cyc, exp_cyc);
    exp_q.delete();
    @(posedge clk); #1;
    check("dump_single_done", done_cnt - d0, 1);
  endtask

  initial begin
    int cyc;
    int b0;
    int d0;
    logic [31:0] a;
    reset = 1; rd_len = 0; rd_sgn = 0; rd_addr = BASE; wr_len = 0; wr_addr = BASE; wr_data = 0;
    start = 0; first_a = BASE; last_a = BASE; full = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", err, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_state", state_dbg, 0);
    @(posedge clk); #1;

    do_store(BASE + 4, 2'b11, 32'h11223344);
    do_load(BASE + 4, 2'b11, 0);
    do_load(BASE + 4, 2'b01, 0);
    do_load(BASE + 6, 2'b10, 0);
    do_store(BASE + 9, 2'b01, 32'h0000_0080);
    do_load(BASE + 9, 2'b01, 1);
    do_load(BASE + 9, 2'b01, 0);
    do_store(BASE + 10, 2'b10, 32'h0000_8001);
    do_load(BASE + 10, 2'b10, 1);
    do_load(BASE + 8, 2'b00, 0);
    do_store(BASE + 2, 2'b11, 32'hDEADBEEF);
    do_load(BASE + 0, 2'b11, 0);
    do_load(BASE + 4, 2'b11, 0);
    do_store(BASE + DEPTH, 2'b01, 32'h55);
    do_store(BASE + DEPTH - 4, 2'b11, 32'hA1B2C3D4);
    do_load(BASE + DEPTH - 4, 2'b11, 0);
    do_load(BASE + DEPTH - 2, 2'b11, 0);
    do_load(BASE - 4, 2'b11, 0);
    do_load(BASE + 5, 2'b10, 0);
    do_store(32'hFFFF_FFFF, 2'b00, 32'h1);

    run_dump(BASE + 4, BASE + 7, 1, 0, 4, -1);
    run_dump(BASE + 8, BASE + 11, 0, 0, 4, 5);
    run_dump(BASE + 7, BASE + 4, 0, 1, 0, 1);
    run_dump(BASE + 4, BASE + DEPTH, 0, 1, 0, 1);
    run_dump(BASE - 1, BASE + 2, 0, 1, 0, 1);
    run_dump(BASE + DEPTH - 4, BASE + DEPTH - 1, 2, 0, 4, -1);

    // Reset in the middle of a dump, after two accepted beats.
    b0 = beat_cnt; d0 = done_cnt; cyc = 0;
    for (int i = 4; i <= 7; i++) exp_q.push_back(model[i]);
    first_a = BASE + 4; last_a = BASE + 7; start = 1;
    @(posedge clk); #1;
    start = 0;
    while (beat_cnt < b0 + 2 && cyc < 20) begin @(negedge clk); #1; cyc++; end
    check("mid_reset_beats", beat_cnt - b0, 2);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    check("mid_reset_req", req, 0);
    check("mid_reset_state", state_dbg, 0);
    repeat (3) @(posedge clk);
    #1 check("mid_reset_no_done", done_cnt - d0, 0);
    do_load(BASE + 4, 2'b11, 0);
    do_load(BASE + DEPTH - 4, 2'b11, 0);
    do_store(BASE + 4, 2'b11, 32'h5A6B7C8D);
    run_dump(BASE + 4, BASE + 7, 0, 0, 4, 5);

    // Random loads and stores around the window edges, then random dumps.
    for (int it = 0; it < 120; it++) begin
      a = BASE + 32'($urandom_range(0, DEPTH + 4));
      if ($urandom_range(0, 15) == 0) a = BASE - 32'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) do_store(a, 2'($urandom_range(0, 3)), $urandom);
      else                           do_load(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int it = 0; it < 6; it++) begin
      int off = $urandom_range(0, DEPTH - 1);
      int len = $urandom_range(0, (DEPTH - 1 - off) < 8 ? (DEPTH - 1 - off) : 8);
      run_dump(BASE + 32'(off), BASE + 32'(off + len), 2, 0, len + 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_memory_dump.md
# data_memory_dump

Parametrised, byte-addressable, big-endian data memory for the single-cycle RISC-V core, with a programmable post-execution dump channel. It serves byte, halfword and word loads and stores from the execute/memory stage with combinational reads and clocked writes. It flags misaligned and out-of-range accesses instead of silently corrupting memory. A start-triggered state machine streams any address window, one byte per accepted beat, to the UART transmitter.

## Interface
- BASE_ADDR, 32'h0000_0000: byte address of the first memory location.
- DEPTH_BYTES, 1024: number of bytes; a multiple of 4, at least 4.
- SYS_clk  in  1  single clock; all state updates on the rising edge.
- SYS_reset  in  1  synchronous, active-high reset.
- MEM_read_length  in  2  01 byte, 10 halfword, 11 or 00 word.
- MEM_read_signed  in  1  sign-extends byte and halfword loads.
- MEM_read_address  in  32  load byte address.
- MEM_read_data  out  32  load result, combinational.
- MEM_read_fault  out  1  load is misaligned or out of range, combinational.
- MEM_write_length  in  2  00 none, 01 byte, 10 halfword, 11 word.
- MEM_write_address  in  32  store byte address.
- MEM_write_data  in  32  store data, right-aligned.
- MEM_write_fault  out  1  store is misaligned or out of range, combinational.
- dump_start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- dump_first  in  32  first byte address of the dump window; latched at start.
- dump_last  in  32  last byte address of the dump window, inclusive; latched at start.
- transmitter_buffer_full  in  1  the transmitter cannot accept a byte this cycle.
- DMEM_transmit_request  out  1  a valid dump byte is presented.
- DMEM_data_transmit  out  8  the dump byte.
- dump_busy  out  1  high in SEND.
- dump_done  out  1  one-cycle pulse when a dump ends.
- dump_error  out  1  sticky flag: the last dump request had an invalid window; cleared by the next accepted start or by reset.

## Operation
- Offset: off = addr − BASE_ADDR, computed as 32-bit unsigned.
- An access of length L (1, 2 or 4) is in range iff DEPTH_BYTES ≥ L and off ≤ DEPTH_BYTES − L. No wrap-around is possible.
- Alignment: a halfword requires addr[0]=0; a word requires addr[1:0]=0.
- Fault = misaligned OR out of range.
- Big-endian layout: byte off holds the most significant byte.
  - Word = {m[off], m[off+1], m[off+2], m[off+3]}.
  - Halfword = {m[off], m[off+1]}.
- Loads:
  - Zero-extend, or sign-extend from bit 7 (byte) or bit 15 (halfword).
  - A faulting load returns 32'h0 and asserts MEM_read_fault.
- Stores:
  - Byte writes data[7:0].
  - Halfword writes data[15:8] then data[7:0].
  - Word writes data[31:24] down to data[7:0].
  - A faulting store writes nothing and asserts MEM_write_fault.
  - write_length 00 never faults.
- Reset clears every byte to 0 in that cycle. Reset has priority over stores and over the dump FSM.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE → SEND on dump_start when the window is valid. A valid window has both dump_first and dump_last in range and dump_first ≤ dump_last. On this transition ptr := dump_first, end := dump_last, and dump_error is cleared.
  - IDLE → DONE on dump_start with an invalid window. dump_error is set and no beats are sent.
  - SEND: DMEM_transmit_request = 1 and DMEM_data_transmit = m[ptr − BASE_ADDR]. A beat is accepted when request=1 and transmitter_buffer_full=0. On an accepted beat: if ptr = end → DONE, else ptr := ptr + 1.
  - DONE: dump_done = 1 for one cycle, then → IDLE.
- Stores during SEND are allowed. The byte presented is always the current memory content, so a store to ptr in cycle n is visible in cycle n+1.
- dump_start is ignored in SEND and DONE.

## Timing
- Loads are zero-latency combinational from address, length and signedness. Stores take effect at the clock edge; a load in the following cycle sees the new data.
- Dump throughput is 1 byte/cycle while transmitter_buffer_full=0. A window of N bytes with no stalls takes one start cycle, N SEND cycles, then one DONE cycle.
- Holding full=1 stalls indefinitely; ptr and the data held on DMEM_data_transmit stay stable.
- Reset values: state IDLE, DMEM_transmit_request 0, dump_busy 0, dump_done 0, dump_error 0, ptr = BASE_ADDR, DMEM_data_transmit = m[0] = 0.
- Reset asserted mid-dump: the next cycle is IDLE with request 0 and no dump_done pulse.

## Test plan
- Store word 32'h11223344 at BASE+4. Load word at BASE+4 → 32'h11223344. Load byte unsigned at BASE+4 → 32'h00000011. Load halfword at BASE+6 → 32'h00003344.
- Store byte 8'h80 at BASE+9. Load byte signed at BASE+9 → 32'hFFFFFF80; unsigned → 32'h00000080. Store halfword 16'h8001 at BASE+10, load signed → 32'hFFFF8001.
- Store word at BASE+2 → MEM_write_fault=1 and memory unchanged. Store byte at BASE+DEPTH_BYTES → fault. Word load at BASE+DEPTH_BYTES−4 → no fault. Load with address below BASE → fault and read data 0.
- Dump window BASE+4..BASE+7, with transmitter_buffer_full toggling 0,1,1,0,… → bytes 11,22,33,44 each delivered exactly once, in order; dump_done pulses once; dump_busy falls in the same cycle.
- dump_first > dump_last, or dump_last out of range → DONE in the next cycle, dump_error=1, no request beats. A subsequent valid start clears dump_error.
- Assert SYS_reset after 2 accepted beats → request=0 in the next cycle, all memory reads 0, no dump_done. A new dump afterwards restarts from dump_first.
